// File: rtl/beam_threshold_loader.sv
// Beamformer threshold loader: shadow table of per-beam thresholds, serial
// push with one-hot beam enables, then a single commit pulse to the trigger block.
module beam_threshold_loader #(
    parameter int unsigned NBEAMS         = 48,
    parameter int unsigned THRESH_BITS    = 18,
    parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = {THRESH_BITS{1'b1}},
    parameter int unsigned UPDATE_GAP     = 2,
    parameter int unsigned AW             = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [THRESH_BITS-1:0] wr_data_i,
    input  logic [AW-1:0]          rd_addr_i,
    output logic [THRESH_BITS-1:0] rd_data_o,
    input  logic                   load_req_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [THRESH_BITS-1:0] thresh_o,
    output logic [NBEAMS-1:0]      thresh_ce_o,
    output logic                   update_o
);

    localparam logic [AW-1:0]     LAST_BEAM = AW'(NBEAMS - 1);
    localparam logic [3:0]        GAP_END   = 4'(UPDATE_GAP);
    localparam logic [NBEAMS-1:0] CE_ONE    = NBEAMS'(1);

    typedef enum logic [1:0] {IDLE, LOAD, GAP, COMMIT} state_t;

    state_t                 state;
    logic [AW-1:0]          beam;
    logic [3:0]             gap_cnt;
    logic                   pending;
    logic [THRESH_BITS-1:0] shadow [NBEAMS];
    logic [THRESH_BITS-1:0] rd_mux;
    logic [THRESH_BITS-1:0] cur_val;

    // Shadow table: writes accepted in every state, out-of-range addresses dropped
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NBEAMS); i++) begin
            if (rst_i) begin
                shadow[i] <= DEFAULT_THRESH;
            end else if (wr_en_i && (wr_addr_i == AW'(i))) begin
                shadow[i] <= wr_data_i;
            end
        end
    end

    // Read mux (0 when out of range) and the value for the beam being presented,
    // which forwards a same-edge write so it goes out in this pass
    always_comb begin
        rd_mux  = '0;
        cur_val = '0;
        for (int i = 0; i < int'(NBEAMS); i++) begin
            if (rd_addr_i == AW'(i)) rd_mux = shadow[i];
            if (beam == AW'(i))      cur_val = shadow[i];
        end
        if (wr_en_i && (wr_addr_i == beam)) cur_val = wr_data_i;
    end

    // Registered read-back; a same-edge write is seen one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_o <= '0;
        else       rd_data_o <= rd_mux;
    end

    // Load sequencer: IDLE -> LOAD (one beam per cycle) -> GAP -> COMMIT -> IDLE/LOAD
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            beam        <= '0;
            gap_cnt     <= '0;
            pending     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            update_o    <= 1'b0;
            thresh_ce_o <= '0;
            thresh_o    <= '0;
        end else begin
            done_o      <= 1'b0;
            update_o    <= 1'b0;
            thresh_ce_o <= '0;
            thresh_o    <= '0;
            case (state)
                IDLE: begin
                    if (load_req_i) begin
                        state  <= LOAD;
                        beam   <= '0;
                        busy_o <= 1'b1;
                    end
                end
                LOAD: begin
                    thresh_ce_o <= CE_ONE << beam;
                    thresh_o    <= cur_val;
                    if (load_req_i) pending <= 1'b1;
                    if (beam == LAST_BEAM) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        beam <= beam + AW'(1);
                    end
                end
                GAP: begin
                    if (load_req_i) pending <= 1'b1;
                    if (gap_cnt == GAP_END) begin
                        update_o <= 1'b1;
                        state    <= COMMIT;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                COMMIT: begin
                    done_o  <= 1'b1;
                    pending <= 1'b0;
                    if (pending || load_req_i) begin
                        state <= LOAD;
                        beam  <= '0;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/beam_threshold_loader.md
Name: beam_threshold_loader

Overview:
- Initiator side of the beamformer threshold-load interface (thresh / thresh_ce / update) that feeds the beam trigger block.
- Holds a shadow table with one 18-bit threshold per beam, written and read back from a simple register-style port.
- On request, pushes every entry serially with a one-hot per-beam clock enable, then issues one commit (update) pulse so all beams switch to the new thresholds together.

Parameters:
NBEAMS, 48, number of beams / thresh_ce_o width (1..64)
THRESH_BITS, 18, threshold width; fixed by the beamformer interface
DEFAULT_THRESH, 18'h3FFFF, shadow value at reset (max threshold, effectively no triggers)
UPDATE_GAP, 2, idle cycles between last thresh_ce_o and update_o (0..15)
AW, $clog2(NBEAMS) (min 1), address width

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  synchronous active-high reset
wr_en_i  in  1  write strobe, single cycle
wr_addr_i  in  AW  beam index to write
wr_data_i  in  THRESH_BITS  threshold value
rd_addr_i  in  AW  read-back index
rd_data_o  out  THRESH_BITS  shadow[rd_addr_i], 1-cycle latency
load_req_i  in  1  start-load request, level sampled each cycle
busy_o  out  1  load sequence in progress
done_o  out  1  1-cycle pulse when sequence completes
thresh_o  out  THRESH_BITS  threshold being presented
thresh_ce_o  out  NBEAMS  one-hot beam enable, aligned with thresh_o
update_o  out  1  1-cycle commit pulse

Behaviour:
- Reset (rst_i high at an edge):
  - shadow[*] = DEFAULT_THRESH.
  - FSM returns to IDLE; pending flag cleared.
  - busy_o, done_o, update_o, thresh_ce_o, thresh_o, rd_data_o all 0.
  - Reset mid-sequence aborts immediately; no update_o is issued.
- Writes:
  - wr_en_i with wr_addr_i < NBEAMS updates shadow at that edge.
  - wr_addr_i >= NBEAMS is ignored.
  - Writes are accepted in every FSM state.
- Read-back:
  - rd_data_o is registered.
  - A read of an address written on the same edge returns the old value; the next cycle returns the new value.
  - rd_addr_i >= NBEAMS returns 0.
- FSM states: IDLE -> LOAD -> GAP -> COMMIT -> IDLE.
  - IDLE: load_req_i high at edge N -> LOAD, beam counter k = 0, busy_o = 1 after edge N.
  - LOAD: at edge N+1+k, thresh_o = shadow[k] (value sampled at that edge, including a same-edge write) and thresh_ce_o = (1 << k). The counter increments; after k = NBEAMS-1 go to GAP.
    - A write to index j is sent in this sequence only if it lands at or before the edge that presents j; otherwise it waits for the next load.
  - GAP: thresh_ce_o = 0, thresh_o = 0. Hold UPDATE_GAP cycles; with UPDATE_GAP = 0, go directly to COMMIT.
  - COMMIT: update_o = 1 for exactly one cycle, at edge N+1+NBEAMS+UPDATE_GAP. At the next edge: update_o = 0, busy_o = 0, done_o = 1 for one cycle, state IDLE.
- Invariants:
  - thresh_ce_o is always zero or one-hot.
  - update_o never coincides with any thresh_ce_o bit.
  - Exactly NBEAMS enables precede each update_o.
- Load request during busy:
  - load_req_i high while busy_o = 1 sets a pending flag.
  - On completion, if pending: clear it and re-enter LOAD on the done_o edge.
    - done_o still pulses.
    - busy_o stays 1 with no low cycle.
    - First enable of the new pass appears 1 cycle after done_o.
  - Multiple requests while busy collapse into one pending pass.
- load_req_i held high continuously: back-to-back passes, each ending in done_o.
- Total sequence length from request edge to done_o: NBEAMS + UPDATE_GAP + 2 cycles.

Test Plan:
- Reset with NBEAMS=4, UPDATE_GAP=2; read all addresses -> rd_data_o = 3FFFF each, one cycle after address; all outputs 0 during and after reset.
- Write 100, 200, 300, 400 to beams 0-3, pulse load_req_i at edge N:
  - ce = 1, 2, 4, 8 at edges N+1..N+4 with thresh_o = 100..400;
  - ce = 0 at N+5 and N+6; update_o at N+7; done_o at N+8; busy_o high N..N+7.
- During the load, write beam 3 = 999 at edge N+2 -> sent as 999 at N+4. Write beam 0 = 555 at N+3 -> not sent this pass; a second load sends 555.
- load_req_i pulsed at N+3 and N+5 -> exactly one extra pass: next ce = 1 at N+9, busy_o never low, two done_o pulses total.
- rst_i at edge N+2 mid-load -> ce/update/busy 0 from N+2; no update_o ever issued; shadow back to 3FFFF; a new request yields a full clean sequence.
- Write addr 5 with NBEAMS=4 -> no shadow change, read addr 5 returns 0. With UPDATE_GAP=0: update_o follows the last ce in the very next cycle.
